// File: rtl/wishbone_led_bank.sv
// Wishbone slave with a small LED register bank: control, LED value, toggle port, blink divider and ID.
// Single outstanding request, optional wait states, byte-lane writes and an error response for bad accesses.
module wishbone_led_bank #(
   parameter int          DW          = 32,
   parameter int          AW          = 3,
   parameter int          N_LEDS      = 8,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h4C45_4401
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [AW-1:0]     i_wb_addr,
   input  logic [DW/8-1:0]   i_wb_sel,
   input  logic [DW-1:0]     i_wb_idata,
   output logic              o_wb_ack,
   output logic              o_wb_stall,
   output logic              o_wb_err,
   output logic [DW-1:0]     o_wb_odata,
   output logic [N_LEDS-1:0] o_led
);

   localparam int       SW      = DW / 8;
   localparam bit       NO_WAIT = (WAIT_STATES == 0);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        stateQ, stateD;
   logic [2:0]        waitQ, waitD;
   logic              weQ, errQ;
   logic [AW-1:0]     addrQ;
   logic [SW-1:0]     selQ;
   logic [DW-1:0]     dataQ;
   logic [2:0]        ctrlQ, ctrlD;
   logic [N_LEDS-1:0] ledOutQ, ledOutD;
   logic [DW-1:0]     divQ, divD;
   logic [DW-1:0]     cntQ, cntD;
   logic              phaseQ, phaseD;
   logic [N_LEDS-1:0] ledQ, ledD;

   logic              accept, goResp, commit, reqErr, reqWe, divWrite, respLive;
   logic [AW-1:0]     reqAddr;
   logic [SW-1:0]     reqSel;
   logic [DW-1:0]     reqData, laneMask, rdData;
   logic [31:0]       reqAddrExt, rdAddrExt;

   // The request is taken straight from the bus when accepted, otherwise from the latched copy.
   assign accept     = (stateQ == S_IDLE) && i_wb_cyc && i_wb_stb;
   assign reqWe      = accept ? i_wb_we    : weQ;
   assign reqAddr    = accept ? i_wb_addr  : addrQ;
   assign reqSel     = accept ? i_wb_sel   : selQ;
   assign reqData    = accept ? i_wb_idata : dataQ;
   assign reqAddrExt = 32'(reqAddr);
   assign rdAddrExt  = 32'(addrQ);
   assign reqErr     = (reqAddrExt > 32'd4) || (reqWe && (reqAddrExt == 32'd4));
   assign goResp     = (accept && NO_WAIT) || ((stateQ == S_WAIT) && i_wb_cyc && (waitQ == 3'd0));
   assign commit     = goResp && reqWe && !reqErr;

   always_comb begin
      for (int i = 0; i < DW; i++) laneMask[i] = reqSel[i/8];
   end

   // Request sequencing; dropping cyc while waiting abandons the request.
   always_comb begin
      stateD = stateQ;
      waitD  = waitQ;
      case (stateQ)
         S_IDLE: if (accept) begin
            if (NO_WAIT) stateD = S_RESP;
            else begin
               stateD = S_WAIT;
               waitD  = 3'(WAIT_STATES - 1);
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc)           stateD = S_IDLE;
            else if (waitQ == 3'd0)  stateD = S_RESP;
            else                     waitD  = waitQ - 3'd1;
         end
         default: stateD = S_IDLE;
      endcase
   end

   // Register writes land on the edge that enters the response state.
   always_comb begin
      ctrlD    = ctrlQ;
      ledOutD  = ledOutQ;
      divD     = divQ;
      divWrite = 1'b0;
      if (commit) begin
         case (reqAddrExt)
            32'd0: ctrlD = (ctrlQ & ~laneMask[2:0]) | (reqData[2:0] & laneMask[2:0]);
            32'd1: ledOutD = (ledOutQ & ~laneMask[N_LEDS-1:0]) | (reqData[N_LEDS-1:0] & laneMask[N_LEDS-1:0]);
            32'd2: ledOutD = ledOutQ ^ (reqData[N_LEDS-1:0] & laneMask[N_LEDS-1:0]);
            32'd3: begin
               divD     = (divQ & ~laneMask) | (reqData & laneMask);
               divWrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Blink divider: the phase flips each time the counter reaches the divider value.
   always_comb begin
      cntD   = cntQ + DW'(1);
      phaseD = phaseQ;
      if (!ctrlQ[2] || divWrite) begin
         cntD   = '0;
         phaseD = 1'b0;
      end else if (cntQ == divQ) begin
         cntD   = '0;
         phaseD = ~phaseQ;
      end
      ledD = ctrlQ[0] ? ((ledOutQ ^ {N_LEDS{ctrlQ[1]}}) & {N_LEDS{~ctrlQ[2] | phaseQ}}) : '0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         stateQ  <= S_IDLE;
         waitQ   <= '0;
         weQ     <= 1'b0;
         errQ    <= 1'b0;
         addrQ   <= '0;
         selQ    <= '0;
         dataQ   <= '0;
         ctrlQ   <= '0;
         ledOutQ <= '0;
         divQ    <= '0;
         cntQ    <= '0;
         phaseQ  <= 1'b0;
         ledQ    <= '0;
      end else begin
         stateQ  <= stateD;
         waitQ   <= waitD;
         if (accept) begin
            weQ   <= i_wb_we;
            errQ  <= reqErr;
            addrQ <= i_wb_addr;
            selQ  <= i_wb_sel;
            dataQ <= i_wb_idata;
         end
         ctrlQ   <= ctrlD;
         ledOutQ <= ledOutD;
         divQ    <= divD;
         cntQ    <= cntD;
         phaseQ  <= phaseD;
         ledQ    <= ledD;
      end
   end

   always_comb begin
      rdData = '0;
      case (rdAddrExt)
         32'd0:   rdData = DW'(ctrlQ);
         32'd1:   rdData = DW'(ledOutQ);
         32'd3:   rdData = divQ;
         32'd4:   rdData = DW'(ID_VALUE);
         default: rdData = '0;
      endcase
   end

   // The response is withheld if the master has already dropped the cycle.
   assign respLive   = (stateQ == S_RESP) && i_wb_cyc;
   assign o_wb_ack   = respLive && !errQ;
   assign o_wb_err   = respLive && errQ;
   assign o_wb_stall = (stateQ != S_IDLE);
   assign o_wb_odata = o_wb_ack ? rdData : '0;
   assign o_led      = ledQ;

endmodule

// File: tb/tb_wishbone_led_bank.sv
// Self-checking bench for wishbone_led_bank: one instance without wait states, one with three,
// each checked against a register-level model of the LED bank.
module tb_wishbone_led_bank;

   localparam logic [31:0] ID = 32'h4C45_4401;

   logic        clk = 1'b0;
   logic        rstN[2];
   logic        cyc[2], stb[2], we[2];
   logic [2:0]  addr[2];
   logic [3:0]  sel[2];
   logic [31:0] wdata[2];
   logic        ack[2], err[2], stall[2];
   logic [31:0] rdata[2];
   logic [7:0]  led[2];

   int errors = 0;
   int checks = 0;

   logic [2:0]  mCtrl[2];
   logic [7:0]  mLed[2];
   logic [31:0] mDiv[2];

   always #5 clk = ~clk;

   wishbone_led_bank #(.WAIT_STATES(0)) dut0 (
      .i_clk(clk), .i_reset_n(rstN[0]), .i_wb_cyc(cyc[0]), .i_wb_stb(stb[0]), .i_wb_we(we[0]),
      .i_wb_addr(addr[0]), .i_wb_sel(sel[0]), .i_wb_idata(wdata[0]), .o_wb_ack(ack[0]),
      .o_wb_stall(stall[0]), .o_wb_err(err[0]), .o_wb_odata(rdata[0]), .o_led(led[0]));

   wishbone_led_bank #(.WAIT_STATES(3)) dut1 (
      .i_clk(clk), .i_reset_n(rstN[1]), .i_wb_cyc(cyc[1]), .i_wb_stb(stb[1]), .i_wb_we(we[1]),
      .i_wb_addr(addr[1]), .i_wb_sel(sel[1]), .i_wb_idata(wdata[1]), .o_wb_ack(ack[1]),
      .o_wb_stall(stall[1]), .o_wb_err(err[1]), .o_wb_odata(rdata[1]), .o_led(led[1]));

   function automatic logic [31:0] maskMerge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [7:0] expLed(input int d);
      return mCtrl[d][0] ? (mLed[d] ^ {8{mCtrl[d][1]}}) : 8'h00;
   endfunction

   // Register-level model: applies one access and predicts error and read data.
   task automatic mAccess(input int d, input bit w, input logic [2:0] a, input logic [3:0] s,
                          input logic [31:0] dt, output bit expErr, output logic [31:0] expRd);
      logic [31:0] t;
      logic [31:0] byteMask;
      expErr = (a > 3'd4) || (w && a == 3'd4);
      expRd  = 32'h0;
      byteMask = maskMerge(32'h0, 32'hFFFF_FFFF, s);
      if (!expErr) begin
         if (w) begin
            case (a)
               3'd0: begin t = maskMerge({29'b0, mCtrl[d]}, dt, s); mCtrl[d] = t[2:0]; end
               3'd1: begin t = maskMerge({24'b0, mLed[d]}, dt, s); mLed[d] = t[7:0]; end
               3'd2: begin t = dt & byteMask; mLed[d] = mLed[d] ^ t[7:0]; end
               3'd3: mDiv[d] = maskMerge(mDiv[d], dt, s);
               default: ;
            endcase
         end else begin
            case (a)
               3'd0: expRd = {29'b0, mCtrl[d]};
               3'd1: expRd = {24'b0, mLed[d]};
               3'd3: expRd = mDiv[d];
               3'd4: expRd = ID;
               default: expRd = 32'h0;
            endcase
         end
      end
   endtask

   task automatic mReset(input int d);
      mCtrl[d] = 3'b0; mLed[d] = 8'h0; mDiv[d] = 32'h0;
   endtask

   // One bus transaction; returns at the falling edge where the response was seen.
   task automatic xfer(input int d, input bit w, input logic [2:0] a, input logic [3:0] s, input logic [31:0] dt,
                       output bit gotAck, output bit gotErr, output logic [31:0] rd, output int lat, output int stallCycles);
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = dt;
      gotAck = 1'b0; gotErr = 1'b0; rd = 32'h0; lat = 0; stallCycles = 0;
      while (!gotAck && !gotErr && lat < 20) begin
         @(negedge clk);
         lat++;
         stb[d] = 1'b0;
         if (stall[d]) stallCycles++;
         gotAck = ack[d]; gotErr = err[d]; rd = rdata[d];
      end
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
   endtask

   // Checked access: compares response kind, latency and (for reads/errors) data against the model.
   task automatic access(input int d, input bit w, input logic [2:0] a, input logic [3:0] s, input logic [31:0] dt, input string tag);
      bit gotAck, gotErr, expErr;
      logic [31:0] rd, expRd;
      int lat, sc, expLat;
      expLat = (d == 0) ? 1 : 4;
      mAccess(d, w, a, s, dt, expErr, expRd);
      xfer(d, w, a, s, dt, gotAck, gotErr, rd, lat, sc);
      checks++;
      if (gotAck !== !expErr || gotErr !== expErr) begin
         errors++; $display("[TB] FAIL %s resp: ack=%0b err=%0b expected ack=%0b err=%0b", tag, gotAck, gotErr, !expErr, expErr);
      end
      checks++;
      if (lat !== expLat) begin
         errors++; $display("[TB] FAIL %s latency: got %0d expected %0d", tag, lat, expLat);
      end
      if (!w || expErr) begin
         checks++;
         if (rd !== expRd) begin
            errors++; $display("[TB] FAIL %s rdata: got %h expected %h", tag, rd, expRd);
         end
      end
   endtask

   task automatic test_reset;
      for (int d = 0; d < 2; d++) begin
         rstN[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
         addr[d] = 3'd0; sel[d] = 4'h0; wdata[d] = 32'h0; mReset(d);
      end
      repeat (2) @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 3'd4; sel[0] = 4'hF;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({ack[d], err[d], stall[d], rdata[d], led[d]} !== 43'h0) begin
            errors++; $display("[TB] FAIL reset_outputs dut%0d: ack=%0b err=%0b stall=%0b rdata=%h led=%h expected all 0",
                                d, ack[d], err[d], stall[d], rdata[d], led[d]);
         end
      end
      rstN[0] = 1'b1; rstN[1] = 1'b1;
      @(negedge clk);
      checks++;
      if (ack[0] !== 1'b1 || rdata[0] !== ID) begin
         errors++; $display("[TB] FAIL first_accept: ack=%0b rdata=%h expected ack=1 rdata=%h", ack[0], rdata[0], ID);
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
   endtask

   task automatic test_basic;
      access(0, 1'b1, 3'd0, 4'hF, 32'h3, "basic_ctrl");
      access(0, 1'b1, 3'd1, 4'hF, 32'hA5, "basic_led");
      checks++;
      if (led[0] !== 8'hFF) begin
         errors++; $display("[TB] FAIL led_before_update: got %h expected ff", led[0]);
      end
      @(negedge clk);
      checks++;
      if (led[0] !== 8'h5A) begin
         errors++; $display("[TB] FAIL led_after_update: got %h expected 5a", led[0]);
      end
   endtask

   task automatic test_toggle;
      access(0, 1'b1, 3'd1, 4'hF, 32'h0F, "toggle_init");
      access(0, 1'b1, 3'd2, 4'h1, 32'h0000_00FF, "toggle_lane0");
      access(0, 1'b0, 3'd1, 4'hF, 32'h0, "toggle_read0");
      checks++;
      if (mLed[0] !== 8'hF0) begin
         errors++; $display("[TB] FAIL toggle_model: got %h expected f0", mLed[0]);
      end
      access(0, 1'b1, 3'd2, 4'h2, 32'h0000_00FF, "toggle_lane1");
      access(0, 1'b0, 3'd1, 4'hF, 32'h0, "toggle_read1");
      access(0, 1'b0, 3'd2, 4'hF, 32'h0, "toggle_readback");
   endtask

   task automatic test_error;
      access(0, 1'b1, 3'd6, 4'hF, $urandom, "err_write_unmapped");
      access(0, 1'b1, 3'd4, 4'hF, $urandom, "err_write_id");
      access(0, 1'b0, 3'd5, 4'hF, 32'h0, "err_read_unmapped");
      for (int a = 0; a < 5; a++) access(0, 1'b0, 3'(a), 4'hF, 32'h0, "err_readback");
   endtask

   task automatic test_random;
      logic [31:0] dt;
      logic [2:0]  a;
      for (int i = 0; i < 40; i++) begin
         a  = 3'($urandom_range(0, 7));
         dt = $urandom;
         if (a == 3'd0) dt[2] = 1'b0;
         access(0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), dt, "random");
         @(negedge clk);
         checks++;
         if (led[0] !== expLed(0)) begin
            errors++; $display("[TB] FAIL random_led: got %h expected %h", led[0], expLed(0));
         end
      end
   endtask

   // Blink is checked as a square wave whose half-period is BLINK_DIV+1 cycles.
   task automatic test_blink;
      logic [7:0] smp[24];
      int first;
      logic [7:0] want;
      access(0, 1'b1, 3'd1, 4'hF, 32'hFF, "blink_led");
      access(0, 1'b1, 3'd3, 4'hF, 32'h3, "blink_div");
      access(0, 1'b1, 3'd0, 4'hF, 32'h5, "blink_ctrl");
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         smp[i] = led[0];
      end
      first = -1;
      for (int i = 1; i < 9; i++) if (first < 0 && smp[i] !== smp[i-1]) first = i;
      checks++;
      if (first < 0) begin
         errors++; $display("[TB] FAIL blink_start: no transition in first 9 samples, got %h expected a change", smp[0]);
      end else begin
         for (int i = first; i < 24; i++) begin
            want = (((i - first) / 4) % 2 == 0) ? smp[first] : ~smp[first];
            checks++;
            if (smp[i] !== want || (smp[i] !== 8'h00 && smp[i] !== 8'hFF)) begin
               errors++; $display("[TB] FAIL blink_wave[%0d]: got %h expected %h", i, smp[i], want);
            end
         end
      end
      access(0, 1'b1, 3'd0, 4'hF, 32'h0, "blink_off");
   endtask

   task automatic test_wait_states;
      bit gotAck, gotErr;
      logic [31:0] rd;
      int lat, sc;
      xfer(1, 1'b0, 3'd4, 4'hF, 32'h0, gotAck, gotErr, rd, lat, sc);
      checks++;
      if (!gotAck || gotErr || lat != 4 || sc != 4 || rd !== ID) begin
         errors++; $display("[TB] FAIL wait_read_id: ack=%0b err=%0b lat=%0d stall=%0d rdata=%h expected 1 0 4 4 %h",
                             gotAck, gotErr, lat, sc, rd, ID);
      end
      access(1, 1'b1, 3'd1, 4'hF, 32'h3C, "wait_write_led");
      access(1, 1'b0, 3'd1, 4'hF, 32'h0, "wait_read_led");
      access(1, 1'b1, 3'd7, 4'hF, 32'h1, "wait_err");
   endtask

   task automatic test_abort;
      int spurious;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd1; sel[1] = 4'hF; wdata[1] = 32'hC3 + k;
         @(negedge clk);
         stb[1] = 1'b0;
         checks++;
         if (stall[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_in_wait%0d: stall=%0b expected 1", k, stall[1]);
         end
         if (k == 0) cyc[1] = 1'b0;
         else begin
            rstN[1] = 1'b0;
            mReset(1);
         end
         @(negedge clk);
         checks++;
         if (stall[1] !== 1'b0 || ack[1] !== 1'b0 || err[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_next%0d: stall=%0b ack=%0b err=%0b expected 0 0 0", k, stall[1], ack[1], err[1]);
         end
         cyc[1] = 1'b0; we[1] = 1'b0; rstN[1] = 1'b1;
         spurious = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack[1] || err[1]) spurious++;
         end
         checks++;
         if (spurious != 0) begin
            errors++; $display("[TB] FAIL abort_quiet%0d: got %0d responses expected 0", k, spurious);
         end
         access(1, 1'b0, 3'd1, 4'hF, 32'h0, "abort_readback");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_toggle();
      test_error();
      test_random();
      test_blink();
      test_wait_states();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wishbone_led_bank.md
WISHBONE_LED_BANK -- requirements
Module: wishbone_led_bank

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width in bits (multiple of 8, 16..64).
REQ-002 SHALL have parameter AW, default 3, word address width.
REQ-003 SHALL have parameter N_LEDS, default 8, LED outputs (1..DW).
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra response cycles (0..7).
REQ-005 SHALL have parameter ID_VALUE, default 32'h4C45_4401, value returned by the ID register.
REQ-006 i_clk  input  1  clock; all logic on rising edge.
REQ-007 i_reset_n  input  1  reset, synchronous, active-low.
REQ-008 i_wb_cyc  input  1  bus cycle active.
REQ-009 i_wb_stb  input  1  request strobe.
REQ-010 i_wb_we  input  1  1 = write, 0 = read.
REQ-011 i_wb_addr  input  AW  word address.
REQ-012 i_wb_sel  input  DW/8  byte lane enables.
REQ-013 i_wb_idata  input  DW  write data.
REQ-014 o_wb_ack  output  1  one-cycle success response.
REQ-015 o_wb_stall  output  1  request not accepted this cycle.
REQ-016 o_wb_err  output  1  one-cycle error response.
REQ-017 o_wb_odata  output  DW  read data, valid only with o_wb_ack.
REQ-018 o_led  output  N_LEDS  LED drive.

Function
REQ-019 Register map: 0 CTRL (bit0 EN, bit1 INV, bit2 BLINK; other bits read 0), 1 LED_OUT (bits N_LEDS-1:0), 2 LED_TOGGLE (write-only; XORs write data into LED_OUT; reads 0), 3 BLINK_DIV (full DW), 4 ID (read-only, ID_VALUE zero-extended/truncated to DW); addresses 5..2^AW-1 unmapped.
REQ-020 FSM states IDLE, WAIT, RESP; o_wb_stall = 1 in every state except IDLE.
REQ-021 Acceptance: in IDLE with i_wb_cyc & i_wb_stb -> latch we/addr/sel/data; -> WAIT if WAIT_STATES>0, else -> RESP.
REQ-022 WAIT: count down WAIT_STATES cycles, then -> RESP; total request-to-response latency 1+WAIT_STATES cycles.
REQ-023 RESP: exactly one of o_wb_ack/o_wb_err high for one cycle, then -> IDLE; a new request is accepted no earlier than the IDLE cycle after RESP.
REQ-024 Writes commit in the cycle of entering RESP, per byte lane where i_wb_sel latched bit is 1; lanes with sel 0 unchanged.
REQ-025 o_wb_err (not ack) for: any access to unmapped address; write to ID; read of LED_TOGGLE is NOT an error (returns 0). Errored writes modify nothing.
REQ-026 Read data: o_wb_odata = register value in the RESP cycle, zero on ack-less/err cycles and in IDLE/WAIT.
REQ-027 Abort: i_wb_cyc low in WAIT or RESP -> return to IDLE next cycle, no ack/err, no write committed.
REQ-028 Blink: DW-bit counter increments each cycle while BLINK=1; when counter == BLINK_DIV it wraps to 0 and toggles internal phase; BLINK=0 or BLINK_DIV write clears counter and phase to 0; BLINK_DIV=0 toggles phase every cycle.
REQ-029 o_led = EN ? ((LED_OUT ^ {N_LEDS{INV}}) & {N_LEDS{~BLINK | phase}}) : 0, registered (1-cycle delay from register update).
REQ-030 Simultaneous LED_TOGGLE write and LED_OUT update impossible (single outstanding request); LED_TOGGLE with sel applies only selected lanes.

Reset
REQ-031 While i_reset_n low at a clock edge: FSM -> IDLE, CTRL/LED_OUT/BLINK_DIV/counter/phase = 0, o_wb_ack = o_wb_err = 0, o_wb_stall = 0, o_wb_odata = 0, o_led = 0.
REQ-032 Reset mid-transaction discards the request: no ack/err afterwards, no write committed.
REQ-033 First request accepted in the first cycle with i_reset_n high.

Verification
REQ-034 WAIT_STATES=0: write CTRL=3, LED_OUT=8'hA5 -> ack 1 cycle after each strobe, o_led = 8'h5A one cycle after LED_OUT ack.
REQ-035 WAIT_STATES=3: read ID -> stall high 4 cycles, ack on 4th cycle after accept, o_wb_odata = 32'h4C45_4401.
REQ-036 Write addr 6 and write ID -> o_wb_err pulse, no ack, readback of all registers unchanged.
REQ-037 LED_OUT=8'h0F, write LED_TOGGLE=32'h0000_00FF with sel=4'b0001 -> LED_OUT reads 8'hF0; sel=4'b0010 -> unchanged.
REQ-038 CTRL=5, LED_OUT=8'hFF, BLINK_DIV=3 -> o_led alternates 8'h00/8'hFF every 4 cycles.
REQ-039 WAIT_STATES=3, drop i_wb_cyc in WAIT of a LED_OUT write; separately assert reset in WAIT -> no ack/err, LED_OUT unchanged, stall low next cycle.
